// File: rtl/buzzer_alarm_mux_pkg.sv
// Shared definitions for the buzzer alarm multiplexer: channel mode
// encodings, controller state encodings, default timing constants for a
// 50 MHz clock and the mode-to-entry-state mapping.
package buzzer_alarm_mux_pkg;

  // Per-channel mode, two bits per channel on ch_mode.
  typedef enum logic [1:0] {
    MODE_OFF    = 2'b00,
    MODE_CONT   = 2'b01,
    MODE_PULSE  = 2'b10,
    MODE_SINGLE = 2'b11
  } mode_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CONT   = 3'd1,
    ST_P_ON   = 3'd2,
    ST_P_OFF  = 3'd3,
    ST_SINGLE = 3'd4
  } state_e;

  // Defaults for a 50 MHz clock.
  localparam int unsigned DEF_TONE_HALF  = 47348;      // ~528 Hz tone
  localparam int unsigned DEF_PULSE_HALF = 2_499_999;  // 10 Hz cadence
  localparam int unsigned DEF_BEEP_LEN   = 5_000_000;  // 100 ms beep

  // State entered when a channel in the given mode takes the buzzer.
  function automatic state_e mode_to_state(input mode_e mode);
    case (mode)
      MODE_CONT:   return ST_CONT;
      MODE_PULSE:  return ST_P_ON;
      MODE_SINGLE: return ST_SINGLE;
      default:     return ST_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/buzzer_tone_gen.sv
// Square-wave tone generator. While run is high the half-period counter
// advances and the output toggles each time it reaches tone_half, giving
// tone_half+1 clocks per half-period. clear has priority and returns the
// counter and the output to 0; with neither asserted both hold.
//   clk, rst_n  clock, asynchronous active-low reset
//   run         advance the tone counter this cycle
//   clear       force counter and output to 0 this cycle
//   tone_half   half-period divisor (runtime)
//   buzz        registered square-wave output
module buzzer_tone_gen #(
  parameter int TONE_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic              clear,
  input  logic [TONE_W-1:0] tone_half,
  output logic              buzz
);

  localparam logic [TONE_W-1:0] TONE_ONE = TONE_W'(1);

  logic [TONE_W-1:0] tone_cnt_q, tone_cnt_d;
  logic              buzz_q, buzz_d;

  // NOTE: every variable gets a default at the top of the block so no path
  // leaves it unassigned; that is what keeps combinational logic latch-free.
  always_comb begin
    tone_cnt_d = tone_cnt_q;
    buzz_d     = buzz_q;
    if (clear) begin
      tone_cnt_d = '0;
      buzz_d     = 1'b0;
    end else if (run) begin
      // >= rather than == so lowering tone_half below the running count
      // toggles on the next edge instead of wrapping the counter.
      if (tone_cnt_q >= tone_half) begin
        tone_cnt_d = '0;
        buzz_d     = ~buzz_q;
      end else begin
        tone_cnt_d = tone_cnt_q + TONE_ONE;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tone_cnt_q <= '0;
      buzz_q     <= 1'b0;
    end else begin
      tone_cnt_q <= tone_cnt_d;
      buzz_q     <= buzz_d;
    end
  end

  assign buzz = buzz_q;

endmodule

// File: rtl/buzzer_alarm_mux.sv
// Multi-channel buzzer driver. Up to N_CH alarm sources, each in a runtime
// mode (continuous, pulsed cadence, single beep), are arbitrated by fixed
// priority (channel 0 highest) onto one square-wave buzzer output.
//   clk, rst_n  clock, asynchronous active-low reset
//   ch_req      per-channel level request
//   ch_mode     per-channel mode, bits [2i+1:2i]
//   tone_half   tone half-period = tone_half+1 clocks
//   pulse_half  pulsed on-time = off-time = pulse_half+1 clocks
//   beep_len    single-beep tone duration in clocks
//   buzz        registered buzzer drive
//   busy        a channel currently owns the buzzer
//   active_ch   owning channel index (0 when idle)
module buzzer_alarm_mux
  import buzzer_alarm_mux_pkg::*;
#(
  parameter  int N_CH   = 4,
  parameter  int TONE_W = 16,
  parameter  int TIME_W = 23,
  localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_CH-1:0]     ch_req,
  input  logic [2*N_CH-1:0]   ch_mode,
  input  logic [TONE_W-1:0]   tone_half,
  input  logic [TIME_W-1:0]   pulse_half,
  input  logic [TIME_W-1:0]   beep_len,
  output logic                buzz,
  output logic                busy,
  output logic [CH_W-1:0]     active_ch
);

  localparam logic [TIME_W-1:0] CAD_ONE = TIME_W'(1);

  state_e            state_q, state_d;
  mode_e             mode_q, mode_d;
  logic [CH_W-1:0]   owner_q, owner_d;
  logic              busy_q, busy_d;
  logic [TIME_W-1:0] cad_cnt_q, cad_cnt_d;
  logic [N_CH-1:0]   done_q, done_d;

  logic [TIME_W:0]   cad_plus1;
  logic              single_end;
  logic [N_CH-1:0]   fin, elig;
  logic              win_valid;
  logic [CH_W-1:0]   win_idx;
  mode_e             win_mode;
  logic              owner_change;
  logic              tone_run;

  // Eligibility and fixed-priority arbitration.
  always_comb begin
    cad_plus1  = {1'b0, cad_cnt_q} + {{TIME_W{1'b0}}, 1'b1};
    // The owning single beep completes on this edge: beep_len clocks of tone
    // have elapsed since entry. The finishing channel is masked here so the
    // arbiter hands over on the same edge rather than one cycle later.
    single_end = busy_q && (state_q == ST_SINGLE) && (cad_plus1 >= {1'b0, beep_len});
    fin        = '0;
    elig       = '0;
    win_valid  = 1'b0;
    win_idx    = '0;
    win_mode   = MODE_OFF;
    for (int i = N_CH - 1; i >= 0; i--) begin
      fin[i]  = single_end && (owner_q == CH_W'(i))
                && (mode_e'(ch_mode[2*i +: 2]) == MODE_SINGLE);
      elig[i] = ch_req[i] && (mode_e'(ch_mode[2*i +: 2]) != MODE_OFF)
                && !((mode_e'(ch_mode[2*i +: 2]) == MODE_SINGLE) && (done_q[i] || fin[i]));
      // Descending scan: the last hit is the lowest eligible index.
      if (elig[i]) begin
        win_valid = 1'b1;
        win_idx   = CH_W'(i);
        win_mode  = mode_e'(ch_mode[2*i +: 2]);
      end
    end
    // A new owner, going idle, or the owner's mode changing all restart
    // the tone and cadence from zero.
    owner_change = (win_valid != busy_q)
                   || (win_valid && ((win_idx != owner_q) || (win_mode != mode_q)));
  end

  // Controller next state, cadence counter and done flags.
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    owner_d   = owner_q;
    busy_d    = busy_q;
    cad_cnt_d = cad_cnt_q;
    tone_run  = 1'b0;

    if (owner_change) begin
      busy_d    = win_valid;
      owner_d   = win_valid ? win_idx : '0;
      mode_d    = win_valid ? win_mode : MODE_OFF;
      state_d   = win_valid ? mode_to_state(win_mode) : ST_IDLE;
      cad_cnt_d = '0;
    end else begin
      case (state_q)
        ST_CONT: tone_run = 1'b1;
        ST_P_ON: begin
          if (cad_cnt_q >= pulse_half) begin
            state_d   = ST_P_OFF;
            cad_cnt_d = '0;
          end else begin
            tone_run  = 1'b1;
            cad_cnt_d = cad_cnt_q + CAD_ONE;
          end
        end
        ST_P_OFF: begin
          if (cad_cnt_q >= pulse_half) begin
            state_d   = ST_P_ON;
            cad_cnt_d = '0;
          end else begin
            cad_cnt_d = cad_cnt_q + CAD_ONE;
          end
        end
        // Completion always surfaces as an owner change, so this count
        // stops before it could reach the top of its range.
        ST_SINGLE: begin
          tone_run  = 1'b1;
          cad_cnt_d = cad_cnt_q + CAD_ONE;
        end
        default: ;
      endcase
    end

    for (int i = 0; i < N_CH; i++) begin
      if (!ch_req[i]) begin
        done_d[i] = 1'b0;
      end else if (fin[i]) begin
        done_d[i] = 1'b1;
      end else if (owner_change && win_valid && (win_idx == CH_W'(i))
                   && (win_mode == MODE_SINGLE) && (beep_len == '0)) begin
        // Zero-length beep completes at the moment it takes ownership.
        done_d[i] = 1'b1;
      end else begin
        done_d[i] = done_q[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      mode_q    <= MODE_OFF;
      owner_q   <= '0;
      busy_q    <= 1'b0;
      cad_cnt_q <= '0;
      done_q    <= '0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      owner_q   <= owner_d;
      busy_q    <= busy_d;
      cad_cnt_q <= cad_cnt_d;
      done_q    <= done_d;
    end
  end

  // Anything other than continuing in a tone state silences the buzzer on
  // this edge and zeroes the tone counter.
  buzzer_tone_gen #(
    .TONE_W (TONE_W)
  ) u_tone_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (tone_run),
    .clear     (!tone_run),
    .tone_half (tone_half),
    .buzz      (buzz)
  );

  assign busy      = busy_q;
  assign active_ch = owner_q;

endmodule

// File: tb/tb_buzzer_alarm_mux.sv
// Self-checking bench for buzzer_alarm_mux (N_CH=4). Each stimulus cycle
// pushes the expected {busy, active_ch, buzz} to a scoreboard queue; the
// entry is popped and compared 1 ns after the following rising edge.
// Expected tone levels come from the closed form: n clocks after a tone
// (re)start, buzz = (n / (tone_half+1)) mod 2.
module tb_buzzer_alarm_mux;
  import buzzer_alarm_mux_pkg::*;

  localparam int N_CH   = 4;
  localparam int TONE_W = 16;
  localparam int TIME_W = 23;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N_CH-1:0]   ch_req;
  logic [2*N_CH-1:0] ch_mode;
  logic [TONE_W-1:0] tone_half;
  logic [TIME_W-1:0] pulse_half;
  logic [TIME_W-1:0] beep_len;
  logic              buzz;
  logic              busy;
  logic [1:0]        active_ch;

  always #5 clk = ~clk;

  buzzer_alarm_mux #(
    .N_CH   (N_CH),
    .TONE_W (TONE_W),
    .TIME_W (TIME_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ch_req     (ch_req),
    .ch_mode    (ch_mode),
    .tone_half  (tone_half),
    .pulse_half (pulse_half),
    .beep_len   (beep_len),
    .buzz       (buzz),
    .busy       (busy),
    .active_ch  (active_ch)
  );

  typedef struct packed {
    logic       busy;
    logic [1:0] ch;
    logic       buzz;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Push the expectation for the next edge, wait for it, pop and compare.
  task automatic cyc(input string tag, input logic eb, input logic [1:0] ech, input logic ebz);
    exp_t e;
    e.busy = eb;
    e.ch   = ech;
    e.buzz = ebz;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check({tag, ".busy"},      {31'd0, busy},      {31'd0, e.busy});
    check({tag, ".active_ch"}, {30'd0, active_ch}, {30'd0, e.ch});
    check({tag, ".buzz"},      {31'd0, buzz},      {31'd0, e.buzz});
  endtask

  function automatic logic tone_bit(input int n, input int t);
    return ((n / (t + 1)) % 2) == 1;
  endfunction

  task automatic set_mode(input int ch, input logic [1:0] m);
    ch_mode[2*ch +: 2] = m;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n      = 1'b0;
    ch_req     = '0;
    ch_mode    = '0;
    tone_half  = 16'd3;
    pulse_half = 23'd9;
    beep_len   = 23'd20;

    #12;
    check("reset.busy",      {31'd0, busy},      32'd0);
    check("reset.active_ch", {30'd0, active_ch}, 32'd0);
    check("reset.buzz",      {31'd0, buzz},      32'd0);
    #10 rst_n = 1'b1;
    cyc("idle", 1'b0, 2'd0, 1'b0);

    // Continuous on ch2, tone_half=3: period 8, first rise 4 clocks in.
    set_mode(2, MODE_CONT);
    ch_req[2] = 1'b1;
    for (int n = 0; n <= 20; n++) cyc("cont", 1'b1, 2'd2, tone_bit(n, 3));
    ch_req[2] = 1'b0;
    cyc("cont_off", 1'b0, 2'd0, 1'b0);

    // tone_half=0 toggles every clock.
    tone_half = 16'd0;
    ch_req[2] = 1'b1;
    for (int n = 0; n <= 6; n++) cyc("fast", 1'b1, 2'd2, tone_bit(n, 0));
    ch_req[2] = 1'b0;
    cyc("fast_off", 1'b0, 2'd0, 1'b0);

    // Pulsed on ch1: 10 clocks of 2-clock tone halves, 10 clocks silent.
    tone_half  = 16'd1;
    pulse_half = 23'd9;
    set_mode(1, MODE_PULSE);
    ch_req[1] = 1'b1;
    for (int n = 0; n < 50; n++)
      cyc("pulse", 1'b1, 2'd1, ((n % 20) < 10) ? tone_bit(n % 20, 1) : 1'b0);
    ch_req[1] = 1'b0;
    cyc("pulse_off", 1'b0, 2'd0, 1'b0);

    // Single on ch3, held request: one 20-clock beep, then silent; a
    // one-cycle drop re-arms it.
    beep_len = 23'd20;
    set_mode(3, MODE_SINGLE);
    ch_req[3] = 1'b1;
    for (int r = 0; r < 2; r++) begin
      if (r == 1) begin
        ch_req[3] = 1'b0;
        cyc("single_drop", 1'b0, 2'd0, 1'b0);
        ch_req[3] = 1'b1;
      end
      for (int n = 0; n < 20; n++) cyc("single", 1'b1, 2'd3, tone_bit(n, 1));
      for (int n = 0; n < 5; n++)  cyc("single_done", 1'b0, 2'd0, 1'b0);
    end

    // Preemption: ch0 continuous interrupts ch3 mid-beep; ch3 then replays
    // a fresh full-length beep.
    ch_req[3] = 1'b0;
    cyc("pre_drop", 1'b0, 2'd0, 1'b0);
    ch_req[3] = 1'b1;
    for (int n = 0; n <= 10; n++) cyc("pre_single", 1'b1, 2'd3, tone_bit(n, 1));
    set_mode(0, MODE_CONT);
    ch_req[0] = 1'b1;
    for (int n = 0; n < 12; n++) cyc("preempt", 1'b1, 2'd0, tone_bit(n, 1));
    ch_req[0] = 1'b0;
    for (int n = 0; n < 20; n++) cyc("resume", 1'b1, 2'd3, tone_bit(n, 1));
    for (int n = 0; n < 3; n++)  cyc("resume_done", 1'b0, 2'd0, 1'b0);
    ch_req[3] = 1'b0;
    cyc("resume_off", 1'b0, 2'd0, 1'b0);

    // Simultaneous ch0/ch1 rise: ch0 owns, ch1 takes over fresh when ch0 drops.
    set_mode(1, MODE_CONT);
    ch_req[1:0] = 2'b11;
    for (int n = 0; n < 6; n++) cyc("simul", 1'b1, 2'd0, tone_bit(n, 1));
    ch_req[0] = 1'b0;
    for (int n = 0; n < 5; n++) cyc("simul_ch1", 1'b1, 2'd1, tone_bit(n, 1));
    ch_req = '0;
    cyc("simul_off", 1'b0, 2'd0, 1'b0);

    // Runtime pitch change 7 -> 2 while the tone counter is at 5.
    tone_half = 16'd7;
    ch_req[2] = 1'b1;
    for (int n = 0; n <= 5; n++) cyc("pitch7", 1'b1, 2'd2, tone_bit(n, 7));
    tone_half = 16'd2;
    for (int n = 6; n <= 17; n++) cyc("pitch2", 1'b1, 2'd2, (((n - 6) / 3) % 2) == 0);
    ch_req[2] = 1'b0;
    cyc("pitch_off", 1'b0, 2'd0, 1'b0);

    // Async reset mid-beep on ch1 single; the held request replays in full.
    tone_half = 16'd1;
    set_mode(1, MODE_SINGLE);
    ch_req[1] = 1'b1;
    for (int n = 0; n <= 8; n++) cyc("rst_pre", 1'b1, 2'd1, tone_bit(n, 1));
    #2 rst_n = 1'b0;
    #1;
    check("rst_async.busy",      {31'd0, busy},      32'd0);
    check("rst_async.active_ch", {30'd0, active_ch}, 32'd0);
    check("rst_async.buzz",      {31'd0, buzz},      32'd0);
    @(posedge clk);
    #1;
    check("rst_hold.busy", {31'd0, busy}, 32'd0);
    #2 rst_n = 1'b1;
    for (int n = 0; n < 20; n++) cyc("rst_replay", 1'b1, 2'd1, tone_bit(n, 1));
    cyc("rst_replay_done", 1'b0, 2'd0, 1'b0);
    ch_req = '0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
